spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//  Controller that shares the four SB_SPRAM256KA banks (64K x 16) between two requesters.
//  Port 0 is the J1 I/O SRAM window; port 1 is a DMA/streaming master.
//  Arbitrates round-robin, sequences single-word reads and writes, and drives the bank SLEEP lines.
//  Only the addressed bank is awake; wake-up time is honoured whenever the active bank changes.
//  Sits between the requesters and the four SPRAM primitives at the top level.
// PARAMETERS
//  WAKE_CYCLES  3  idle cycles inserted after a bank's SLEEP deasserts before first access (0 = none)
// PORTS
//  clk          in   1   system clock (12 MHz core clock)
//  reset        in   1   asynchronous, active-high reset
//  p0_req       in   1   port 0 request; held with addr/we/wdata stable until p0_gnt
//  p0_we        in   1   port 0: 1 = write, 0 = read
//  p0_addr      in   16  port 0 word address; [15:14] bank, [13:0] word
//  p0_wdata     in   16  port 0 write data
//  p0_gnt       out  1   port 0 grant pulse; access issued this cycle
//  p0_rvalid    out  1   port 0 read data valid pulse
//  p0_rdata     out  16  port 0 read data (meaningful only while p0_rvalid)
//  p1_*         ...      identical set for port 1 (req, we, addr, wdata, gnt, rvalid, rdata)
//  spram_addr   out  14  shared ADDRESS to all banks
//  spram_din    out  16  shared DATAIN to all banks
//  spram_we     out  1   shared WREN (MASKWREN tied 4'b1111 at top)
//  spram_sleep  out  4   per-bank SLEEP; bit n = bank n
//  spram_dout   in   64  {bank3,bank2,bank1,bank0} DATAOUT
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=IDLE, cur_bank=0, spram_sleep=4'b1110, rr_last=1 (port 0 wins first tie).
//   - spram_we, gnt, rvalid = 0; spram_addr, spram_din = 0.
//   - An in-flight access is abandoned: no gnt/rvalid follows; WREN drops immediately.
//  FSM states IDLE / WAKE / ISSUE
//   - IDLE: if any req, pick winner and latch win_port.
//       Both req -> port != rr_last; one req -> that port.
//       Next state ISSUE if win bank == cur_bank, else WAKE.
//       On entering WAKE: cur_bank <= bank, wake_cnt <= WAKE_CYCLES-1.
//   - WAKE: spram_sleep = ~onehot(cur_bank) already; count down, -> ISSUE when wake_cnt==0.
//       WAKE_CYCLES=0: bank-change path goes straight to ISSUE.
//   - ISSUE (1 cycle):
//       spram_addr=addr[13:0], spram_din=wdata, spram_we=we of winner.
//       pX_gnt=1; rr_last<=win; -> IDLE.
//  Timing and throughput
//   - Same-bank access: req seen at edge N, gnt in cycle N+1.
//   - Max rate: one access per 2 cycles per arbiter.
//   - Read: pX_rvalid=1 in cycle after ISSUE; pX_rdata = spram_dout slice of the bank latched at ISSUE.
//       rvalid/rdata are not registered; SPRAM DATAOUT is registered.
//   - Write: no rvalid.
//  Idle and output hold
//   - spram_sleep keeps last bank awake (no re-wake for repeat accesses).
//   - spram_addr/din hold value outside ISSUE; spram_we=0 outside ISSUE.
//  Simultaneous events
//   - A new req arriving during rvalid cycle is arbitrated normally (rvalid cycle is IDLE).
//   - Fairness: with both ports continuously requesting, grants strictly alternate p0,p1,p0...
//  Protocol errors
//   - Dropping req or changing addr/we/wdata before gnt is a protocol error.
//   - Bench asserts it; RTL behaviour undefined.
//  Widths
//   - Bank index 2 bits; wake_cnt sized $clog2(WAKE_CYCLES+1), min 1 bit.
// TESTING
//  1 Reset, p0 write 0x1234 @0x0005 -> spram_we=1, addr=0x0005, din=0x1234 one cycle; p0_gnt same cycle; no WAKE.
//  2 p0 read @0x0005 after 1 -> p0_gnt, next cycle p0_rvalid=1, p0_rdata=0x1234; sleep=4'b1110 throughout.
//  3 p1 write 0xBEEF @0xC010 (bank 3), WAKE_CYCLES=3 -> sleep=4'b0111 at once; gnt exactly 4 cycles after req sampled.
//  4 p0 and p1 assert req same cycle, held 8 accesses, same bank -> grants p0,p1,p0,p1...; no gnt overlap; gnt every 2nd cycle.
//  5 Assert reset during WAKE and during ISSUE of a write -> no gnt; spram_we low immediately; sleep=4'b1110; next access works.
//  6 Reads back-to-back banks 0,1,0 with WAKE_CYCLES=0 -> no WAKE; rdata taken from correct bank each time.

Source files
------------

// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter sharing four SB_SPRAM256KA banks (64K x 16).
// Sequences single-word accesses and keeps only the addressed bank awake.
module spram_arbiter #(
  parameter int unsigned WAKE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_rdata,
  output logic [13:0] spram_addr,
  output logic [15:0] spram_din,
  output logic        spram_we,
  output logic [3:0]  spram_sleep,
  input  logic [63:0] spram_dout
);

  localparam int unsigned CntW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WakeInit = (WAKE_CYCLES > 0) ? CntW'(WAKE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {StIdle, StWake, StIssue} state_e;

  state_e          state_q;
  logic [1:0]      cur_bank_q;
  logic [1:0]      rd_bank_q;
  logic            rr_last_q;
  logic            win_port_q;
  logic            rd_pend_q;
  logic            rd_port_q;
  logic [CntW-1:0] wake_cnt_q;

  logic        any_req;
  logic        pick;
  logic        cmd_port;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_bank;
  logic        go_issue;

  // In IDLE the fresh arbitration result drives the command; afterwards the latched
  // winner does, relying on requesters holding their inputs until grant.
  always_comb begin
    any_req   = p0_req | p1_req;
    pick      = (p0_req & p1_req) ? ~rr_last_q : p1_req;
    cmd_port  = (state_q == StIdle) ? pick : win_port_q;
    cmd_we    = cmd_port ? p1_we    : p0_we;
    cmd_addr  = cmd_port ? p1_addr  : p0_addr;
    cmd_wdata = cmd_port ? p1_wdata : p0_wdata;
    cmd_bank  = cmd_addr[15:14];
    go_issue  = 1'b0;
    unique case (state_q)
      StIdle:  go_issue = any_req & ((cmd_bank == cur_bank_q) | (WAKE_CYCLES == 0));
      StWake:  go_issue = (wake_cnt_q == '0);
      default: go_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_bank_q  <= 2'd0;
      rd_bank_q   <= 2'd0;
      rr_last_q   <= 1'b1;
      win_port_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= 1'b0;
      wake_cnt_q  <= '0;
      spram_sleep <= 4'b1110;
      spram_addr  <= 14'd0;
      spram_din   <= 16'd0;
      spram_we    <= 1'b0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      spram_we  <= 1'b0;
      rd_pend_q <= 1'b0;
      if (go_issue) begin
        spram_addr <= cmd_addr[13:0];
        spram_din  <= cmd_wdata;
        spram_we   <= cmd_we;
        p0_gnt     <= ~cmd_port;
        p1_gnt     <= cmd_port;
      end
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            win_port_q <= pick;
            wake_cnt_q <= WakeInit;
            if (cmd_bank != cur_bank_q) begin
              cur_bank_q  <= cmd_bank;
              spram_sleep <= ~(4'b0001 << cmd_bank);
            end
            state_q <= go_issue ? StIssue : StWake;
          end
        end
        StWake: begin
          if (wake_cnt_q == '0) begin
            state_q <= StIssue;
          end else begin
            wake_cnt_q <= wake_cnt_q - CntW'(1);
          end
        end
        StIssue: begin
          rr_last_q <= win_port_q;
          rd_pend_q <= ~spram_we;
          rd_port_q <= win_port_q;
          rd_bank_q <= cur_bank_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // SPRAM DATAOUT is already registered, so read data is steered straight through.
  always_comb begin
    p0_rvalid = rd_pend_q & ~rd_port_q;
    p1_rvalid = rd_pend_q & rd_port_q;
    p0_rdata  = spram_dout[{rd_bank_q, 4'b0000} +: 16];
    p1_rdata  = spram_dout[{rd_bank_q, 4'b0000} +: 16];
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: instance 0 uses WAKE_CYCLES=3, instance 1 uses WAKE_CYCLES=0,
// each attached to a behavioural four-bank SPRAM.
module tb_spram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [15:0] addr  [2][2];
  logic [15:0] wdata [2][2];
  wire  [1:0]  gnt    [2];
  wire  [1:0]  rvalid [2];
  wire  [15:0] rdata  [2][2];
  wire  [13:0] s_addr  [2];
  wire  [15:0] s_din   [2];
  wire         s_we    [2];
  wire  [3:0]  s_sleep [2];
  wire  [63:0] s_dout  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: flat word memory plus arbitration history.
  bit [15:0] ref_mem [2][65536];
  bit        ref_vld [2][65536];
  int        last_win   [2];
  int        cur_bank_m [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] mem [4][16384];
    logic [15:0] dout_r [4];
    logic [1:0]  pv_req, pv_gnt, pv_we;
    logic [15:0] pv_addr [2];
    logic [15:0] pv_wd   [2];
    logic        pv_ok;

    spram_arbiter #(.WAKE_CYCLES(g == 0 ? 3 : 0)) dut (
      .clk        (clk),
      .reset      (rst[g]),
      .p0_req     (req[g][0]),
      .p0_we      (we[g][0]),
      .p0_addr    (addr[g][0]),
      .p0_wdata   (wdata[g][0]),
      .p0_gnt     (gnt[g][0]),
      .p0_rvalid  (rvalid[g][0]),
      .p0_rdata   (rdata[g][0]),
      .p1_req     (req[g][1]),
      .p1_we      (we[g][1]),
      .p1_addr    (addr[g][1]),
      .p1_wdata   (wdata[g][1]),
      .p1_gnt     (gnt[g][1]),
      .p1_rvalid  (rvalid[g][1]),
      .p1_rdata   (rdata[g][1]),
      .spram_addr (s_addr[g]),
      .spram_din  (s_din[g]),
      .spram_we   (s_we[g]),
      .spram_sleep(s_sleep[g]),
      .spram_dout (s_dout[g])
    );

    assign s_dout[g] = {dout_r[3], dout_r[2], dout_r[1], dout_r[0]};

    // Only an awake bank reacts; DATAOUT is registered and updates on reads.
    always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (!s_sleep[g][b]) begin
          if (s_we[g]) mem[b][s_addr[g]] <= s_din[g];
          else dout_r[b] <= mem[b][s_addr[g]];
        end
      end
    end

    // Requester protocol: req and its fields must hold until the grant.
    always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
        if (!rst[g] && pv_ok && pv_req[p] && !pv_gnt[p] && !gnt[g][p] &&
            (req[g][p] !== 1'b1 || addr[g][p] !== pv_addr[p] || we[g][p] !== pv_we[p] ||
             wdata[g][p] !== pv_wd[p]))
          $error("protocol violation on instance %0d port %0d", g, p);
        pv_addr[p] <= addr[g][p];
        pv_wd[p]   <= wdata[g][p];
      end
      pv_req <= req[g];
      pv_gnt <= gnt[g];
      pv_we  <= we[g];
      pv_ok  <= !rst[g];
    end
  end

  function automatic int wake_of(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  function automatic logic [3:0] sleep_of(input int b);
    return ~(4'b0001 << b);
  endfunction

  function automatic int exp_lat(input int i, input logic [15:0] a);
    return 1 + ((int'(a[15:14]) != cur_bank_m[i]) ? wake_of(i) : 0);
  endfunction

  task automatic model_grant(input int i, input int p, input bit w, input logic [15:0] a,
                             input logic [15:0] d);
    if (w) begin
      ref_mem[i][a] = d;
      ref_vld[i][a] = 1'b1;
    end
    last_win[i]   = p;
    cur_bank_m[i] = int'(a[15:14]);
  endtask

  task automatic model_reset(input int i);
    last_win[i]   = 1;
    cur_bank_m[i] = 0;
  endtask

  // Single access from one port; called at a negedge, returns at the negedge after grant.
  task automatic access(input int i, input int p, input bit w, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [13:0] o_addr,
                        output logic [15:0] o_din, output logic o_we, output logic [3:0] o_sleep,
                        output logic o_rv, output logic [15:0] o_rdata);
    we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt[i][p] && lat < 20);
    o_addr = s_addr[i]; o_din = s_din[i]; o_we = s_we[i]; o_sleep = s_sleep[i];
    req[i][p] = 1'b0;
    @(negedge clk);
    o_rv = rvalid[i][p]; o_rdata = rdata[i][p];
  endtask

  task automatic gen_txn(input int i, input int p, input int fixed_bank);
    int b;
    logic [15:0] a;
    b = (fixed_bank < 0) ? int'($urandom_range(3)) : fixed_bank;
    a = {b[1:0], 10'h000, 4'($urandom_range(15))};
    addr[i][p]  = a;
    we[i][p]    = ($urandom_range(1) == 1) || !ref_vld[i][a];
    wdata[i][p] = 16'($urandom);
    req[i][p]   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00; we[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin addr[i][p] = '0; wdata[i][p] = '0; end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (gnt[i] !== 2'b00 || rvalid[i] !== 2'b00) begin
        n_fail++; $display("FAIL reset_handshake inst %0d gnt=%b rvalid=%b want 00/00", i, gnt[i], rvalid[i]);
      end
      n_tests++;
      if (s_we[i] !== 1'b0 || s_sleep[i] !== 4'b1110) begin
        n_fail++; $display("FAIL reset_bank inst %0d we=%b sleep=%b want 0/1110", i, s_we[i], s_sleep[i]);
      end
      n_tests++;
      if (s_addr[i] !== 14'h0 || s_din[i] !== 16'h0) begin
        n_fail++; $display("FAIL reset_bus inst %0d addr=%h din=%h want 0/0", i, s_addr[i], s_din[i]);
      end
      model_reset(i);
    end
    rst = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_write_same_bank();
    int lat; logic [13:0] oa; logic [15:0] od, rd; logic ow, rv; logic [3:0] os;
    access(0, 0, 1'b1, 16'h0005, 16'h1234, lat, oa, od, ow, os, rv, rd);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL wr_latency got %0d want 1", lat); end
    n_tests++;
    if (ow !== 1'b1 || oa !== 14'h0005 || od !== 16'h1234) begin
      n_fail++; $display("FAIL wr_bus got we=%b addr=%h din=%h want 1/0005/1234", ow, oa, od);
    end
    n_tests++;
    if (rv !== 1'b0 || s_we[0] !== 1'b0) begin
      n_fail++; $display("FAIL wr_after got rvalid=%b we=%b want 0/0", rv, s_we[0]);
    end
    model_grant(0, 0, 1'b1, 16'h0005, 16'h1234);
  endtask

  task automatic test_read_same_bank();
    int lat; logic [13:0] oa; logic [15:0] od, rd; logic ow, rv; logic [3:0] os;
    access(0, 0, 1'b0, 16'h0005, 16'($urandom), lat, oa, od, ow, os, rv, rd);
    n_tests++;
    if (lat != 1 || ow !== 1'b0) begin
      n_fail++; $display("FAIL rd_issue got lat=%0d we=%b want 1/0", lat, ow);
    end
    n_tests++;
    if (rv !== 1'b1 || rd !== ref_mem[0][16'h0005]) begin
      n_fail++; $display("FAIL rd_data got rvalid=%b rdata=%h want 1/%h", rv, rd, ref_mem[0][16'h0005]);
    end
    n_tests++;
    if (os !== 4'b1110 || s_sleep[0] !== 4'b1110) begin
      n_fail++; $display("FAIL rd_sleep got %b/%b want 1110", os, s_sleep[0]);
    end
    model_grant(0, 0, 1'b0, 16'h0005, 16'h0);
  endtask

  task automatic test_bank_wake();
    int lat, want;
    int lat2; logic [13:0] oa; logic [15:0] od, rd; logic ow, rv; logic [3:0] os;
    want = exp_lat(0, 16'hC010);
    we[0][1] = 1'b1; addr[0][1] = 16'hC010; wdata[0][1] = 16'hBEEF; req[0][1] = 1'b1;
    @(negedge clk);
    lat = 1;
    n_tests++;
    if (s_sleep[0] !== 4'b0111 || gnt[0] !== 2'b00) begin
      n_fail++; $display("FAIL wake_sleep got sleep=%b gnt=%b want 0111/00", s_sleep[0], gnt[0]);
    end
    while (!gnt[0][1] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat != want) begin n_fail++; $display("FAIL wake_latency got %0d want %0d", lat, want); end
    n_tests++;
    if (s_we[0] !== 1'b1 || s_addr[0] !== 14'h0010 || s_din[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL wake_bus got we=%b addr=%h din=%h want 1/0010/beef", s_we[0], s_addr[0], s_din[0]);
    end
    req[0][1] = 1'b0;
    model_grant(0, 1, 1'b1, 16'hC010, 16'hBEEF);
    @(negedge clk);
    access(0, 1, 1'b0, 16'hC010, 16'h0, lat2, oa, od, ow, os, rv, rd);
    n_tests++;
    if (lat2 != 1 || rv !== 1'b1 || rd !== 16'hBEEF) begin
      n_fail++; $display("FAIL wake_readback got lat=%0d rvalid=%b rdata=%h want 1/1/beef", lat2, rv, rd);
    end
    model_grant(0, 1, 1'b0, 16'hC010, 16'h0);
  endtask

  // Both ports request continuously; grants must alternate with model-derived spacing.
  task automatic test_both_ports(input int i, input int n, input int fixed_bank, input string tag);
    int cyc, last_cyc, grants, issued, ep, b, gap;
    logic [1:0]  rv_exp;
    logic [15:0] rv_data [2];
    rv_exp = 2'b00; grants = 0; cyc = 0; last_cyc = 0; ep = 1 - last_win[i];
    gen_txn(i, 0, fixed_bank);
    gen_txn(i, 1, fixed_bank);
    issued = 2;
    for (int guard = 0; guard < 2000; guard++) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (rvalid[i][p] !== rv_exp[p]) begin
          n_fail++; $display("FAIL %s_rvalid port %0d got %b want %b", tag, p, rvalid[i][p], rv_exp[p]);
        end else if (rv_exp[p] && rdata[i][p] !== rv_data[p]) begin
          n_fail++; $display("FAIL %s_rdata port %0d got %h want %h", tag, p, rdata[i][p], rv_data[p]);
        end
      end
      rv_exp = 2'b00;
      if (gnt[i] !== 2'b00) begin
        b   = int'(addr[i][ep][15:14]);
        gap = ((grants == 0) ? 1 : 2) + ((b != cur_bank_m[i]) ? wake_of(i) : 0);
        n_tests++;
        if (gnt[i] !== ((ep == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL %s_order grant %0d got gnt=%b want port %0d", tag, grants, gnt[i], ep);
        end
        n_tests++;
        if (cyc - last_cyc != gap) begin
          n_fail++; $display("FAIL %s_timing grant %0d got gap %0d want %0d", tag, grants, cyc - last_cyc, gap);
        end
        n_tests++;
        if (s_addr[i] !== addr[i][ep][13:0] || s_we[i] !== we[i][ep] ||
            s_din[i] !== wdata[i][ep] || s_sleep[i] !== sleep_of(b)) begin
          n_fail++;
          $display("FAIL %s_bus grant %0d got addr=%h we=%b din=%h sleep=%b want %h/%b/%h/%b", tag,
                   grants, s_addr[i], s_we[i], s_din[i], s_sleep[i], addr[i][ep][13:0], we[i][ep],
                   wdata[i][ep], sleep_of(b));
        end
        if (!we[i][ep]) begin
          rv_exp[ep]  = 1'b1;
          rv_data[ep] = ref_mem[i][addr[i][ep]];
        end
        model_grant(i, ep, we[i][ep], addr[i][ep], wdata[i][ep]);
        if (issued < n) begin
          gen_txn(i, ep, fixed_bank);
          issued++;
        end else begin
          req[i][ep] = 1'b0;
        end
        last_cyc = cyc;
        grants++;
        ep = 1 - ep;
      end
      if (req[i] == 2'b00 && rv_exp == 2'b00) break;
    end
    n_tests++;
    if (grants != n) begin
      n_fail++; $display("FAIL %s_count got %0d grants want %0d", tag, grants, n);
    end
    req[i] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat; logic [13:0] oa; logic [15:0] od, rd; logic ow, rv; logic [3:0] os;
    logic [15:0] keep;
    keep = 16'($urandom);
    access(0, 0, 1'b1, 16'h0020, keep, lat, oa, od, ow, os, rv, rd);
    model_grant(0, 0, 1'b1, 16'h0020, keep);
    // Abort during WAKE.
    we[0][1] = 1'b1; addr[0][1] = 16'h8033; wdata[0][1] = 16'h5555; req[0][1] = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (gnt[0] !== 2'b00) begin n_fail++; $display("FAIL midwake_gnt got %b want 00", gnt[0]); end
    rst[0] = 1'b1; req[0][1] = 1'b0;
    #1;
    n_tests++;
    if (gnt[0] !== 2'b00 || s_we[0] !== 1'b0 || s_sleep[0] !== 4'b1110) begin
      n_fail++; $display("FAIL midwake_reset got gnt=%b we=%b sleep=%b want 00/0/1110", gnt[0], s_we[0], s_sleep[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    // Abort during ISSUE of a write.
    we[0][0] = 1'b1; addr[0][0] = 16'h0020; wdata[0][0] = ~keep; req[0][0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt[0] !== 2'b01 || s_we[0] !== 1'b1) begin
      n_fail++; $display("FAIL midissue_pre got gnt=%b we=%b want 01/1", gnt[0], s_we[0]);
    end
    rst[0] = 1'b1; req[0][0] = 1'b0;
    #1;
    n_tests++;
    if (gnt[0] !== 2'b00 || s_we[0] !== 1'b0 || s_sleep[0] !== 4'b1110) begin
      n_fail++; $display("FAIL midissue_reset got gnt=%b we=%b sleep=%b want 00/0/1110", gnt[0], s_we[0], s_sleep[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    n_tests++;
    if (rvalid[0] !== 2'b00 || gnt[0] !== 2'b00) begin
      n_fail++; $display("FAIL midissue_quiet got rvalid=%b gnt=%b want 00/00", rvalid[0], gnt[0]);
    end
    access(0, 1, 1'b0, 16'h0020, 16'h0, lat, oa, od, ow, os, rv, rd);
    n_tests++;
    if (lat != 1 || rv !== 1'b1 || rd !== ref_mem[0][16'h0020]) begin
      n_fail++; $display("FAIL postreset_read got lat=%0d rvalid=%b rdata=%h want 1/1/%h", lat, rv, rd, ref_mem[0][16'h0020]);
    end
    model_grant(0, 1, 1'b0, 16'h0020, 16'h0);
  endtask

  task automatic test_bank_switch_nowake();
    logic [15:0] seq_a [5];
    bit          seq_w [5];
    logic [15:0] seq_d [5];
    int lat, b; logic [13:0] oa; logic [15:0] od, rd; logic ow, rv; logic [3:0] os;
    seq_a = '{16'h0100, 16'h4100, 16'h0100, 16'h4100, 16'h0100};
    seq_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    seq_d[0] = 16'($urandom);
    seq_d[1] = ~seq_d[0];
    for (int k = 2; k < 5; k++) seq_d[k] = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      b = int'(seq_a[k][15:14]);
      access(1, k % 2, seq_w[k], seq_a[k], seq_d[k], lat, oa, od, ow, os, rv, rd);
      n_tests++;
      if (lat != 1 || os !== sleep_of(b)) begin
        n_fail++; $display("FAIL nowake_step%0d got lat=%0d sleep=%b want 1/%b", k, lat, os, sleep_of(b));
      end
      n_tests++;
      if (rv !== !seq_w[k] || (!seq_w[k] && rd !== ref_mem[1][seq_a[k]])) begin
        n_fail++; $display("FAIL nowake_data%0d got rvalid=%b rdata=%h want %b/%h", k, rv, rd, !seq_w[k], ref_mem[1][seq_a[k]]);
      end
      model_grant(1, k % 2, seq_w[k], seq_a[k], seq_d[k]);
    end
  endtask

  initial begin
    test_reset();
    test_write_same_bank();
    test_read_same_bank();
    test_bank_wake();
    test_both_ports(0, 8, cur_bank_m[0], "fair");
    test_both_ports(0, 40, -1, "rand");
    test_reset_midflight();
    test_bank_switch_nowake();
    test_both_ports(1, 30, -1, "rand_nowake");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
